// File: rtl/instr_encoder.sv
// Packs decoded RISC-V fields (R, I-ALU, load, S, SB) into 32-bit instruction words
// behind a one-entry output register with word addressing and rejected-request accounting.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [6:0]           op_i,
  input  logic [4:0]           rd_i,
  input  logic [4:0]           rs1_i,
  input  logic [4:0]           rs2_i,
  input  logic [2:0]           funct3_i,
  input  logic [6:0]           funct7_i,
  input  logic [31:0]          imm_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [31:0]          instr_o,
  output logic [31:0]          addr_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 7;

  localparam logic [OPW-1:0] OP_R    = 7'b0110011;
  localparam logic [OPW-1:0] OP_I    = 7'b0010011;
  localparam logic [OPW-1:0] OP_LOAD = 7'b0000011;
  localparam logic [OPW-1:0] OP_S    = 7'b0100011;
  localparam logic [OPW-1:0] OP_B    = 7'b1100011;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t                r_state;
  logic [XLEN-1:0]       r_instr;
  logic [XLEN-1:0]       r_addr;
  logic                  r_err;
  logic [ERR_CNT_W-1:0]  r_err_cnt;

  logic                  w_accept;
  logic                  w_xfer;
  logic                  w_legal;
  logic                  w_imm12_ok;
  logic                  w_imm13_ok;
  logic [XLEN-1:0]       w_word;

  assign out_valid_o = (r_state == S_FULL);
  assign instr_o     = r_instr;
  assign addr_o      = r_addr;
  assign err_o       = r_err;
  assign err_cnt_o   = r_err_cnt;

  assign in_ready_o  = !out_valid_o || out_ready_i;
  assign w_accept    = in_valid_i && in_ready_o;
  assign w_xfer      = out_valid_o && out_ready_i;

  // A value fits in N signed bits iff every bit from N-1 upward equals the sign.
  assign w_imm12_ok  = (&imm_i[31:11]) || !(|imm_i[31:11]);
  assign w_imm13_ok  = (&imm_i[31:12]) || !(|imm_i[31:12]);

  // Field packing and legality per opcode
  always_comb begin
    w_legal = 1'b0;
    w_word  = '0;
    case (op_i)
      OP_R: begin
        w_legal = 1'b1;
        w_word  = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, op_i};
      end
      OP_I, OP_LOAD: begin
        w_legal = w_imm12_ok;
        w_word  = {imm_i[11:0], rs1_i, funct3_i, rd_i, op_i};
      end
      OP_S: begin
        w_legal = w_imm12_ok;
        w_word  = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], op_i};
      end
      OP_B: begin
        w_legal = w_imm13_ok && !imm_i[0];
        w_word  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                   imm_i[4:1], imm_i[11], op_i};
      end
      default: begin
        w_legal = 1'b0;
        w_word  = '0;
      end
    endcase
  end

  // Output register, address counter and error accounting
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_EMPTY;
      r_instr   <= '0;
      r_addr    <= BASE_ADDR;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_err <= w_accept && !w_legal;
      if (w_accept && !w_legal && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
      if (w_xfer) begin
        r_addr <= r_addr + XLEN'(4);
      end
      if (r_state == S_EMPTY) begin
        if (w_accept && w_legal) begin
          r_instr <= w_word;
          r_state <= S_FULL;
        end
      end else begin
        // An accept while FULL implies a same-cycle transfer, so the slot is reused.
        if (w_accept && w_legal) begin
          r_instr <= w_word;
        end else if (out_ready_i) begin
          r_state <= S_EMPTY;
        end
      end
    end
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the immediate-generation path: packs decoded fields (opcode, registers, funct3/funct7, 32-bit signed immediate) into 32-bit RISC-V instruction words.
- Covers the five formats the core decodes: R (0110011), I-ALU (0010011), load (0000011), S-store (0100011) and SB-branch (1100011).
- Sits between the test/program generator and instruction memory. A valid/ready handshake on each side, a one-entry output register, a word-address counter and error accounting for illegal requests.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address assigned to the first emitted word.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous reset, active-high.
- in_valid_i  input  1  request fields are valid.
- in_ready_o  output  1  block can accept a request this cycle.
- op_i  input  7  opcode.
- rd_i  input  5  destination register.
- rs1_i  input  5  source register 1.
- rs2_i  input  5  source register 2.
- funct3_i  input  3  funct3 field.
- funct7_i  input  7  funct7 field; R format only.
- imm_i  input  32  signed immediate, byte offset for branches.
- out_valid_o  output  1  instr_o/addr_o hold a word.
- out_ready_i  input  1  consumer accepts the word.
- instr_o  output  32  encoded instruction.
- addr_o  output  32  byte address of instr_o.
- err_o  output  1  one-cycle pulse when a request is rejected.
- err_cnt_o  output  ERR_CNT_W  saturating count of rejected requests.

Behaviour:
- Reset (async, rst_i=1): out_valid_o=0, instr_o=0, addr_o=BASE_ADDR, err_o=0, err_cnt_o=0. Any held word is discarded. in_ready_o=1 once rst_i deasserts.
- States:
  - EMPTY: output register free.
  - FULL: out_valid_o=1.
- in_ready_o = !out_valid_o || out_ready_i (combinational). Enables back-to-back throughput of 1 word/cycle.
- Accept: in_valid_i && in_ready_o at a rising edge.
- Latency: exactly 1 cycle. The word accepted at edge N is visible with out_valid_o=1 after edge N.
- Output transfer: out_valid_o && out_ready_i. On transfer, addr_o advances by 4 with 32-bit wrap-around (FFFF_FFFC -> 0000_0000).
- Simultaneous transfer and accept: the new word replaces the old one, addr_o = old+4, and the state stays FULL.
- While FULL and out_ready_i=0, instr_o and addr_o are held stable.
- Encoding, with opcode in [6:0]:
  - R: {funct7, rs2, rs1, funct3, rd, op}.
  - I-ALU and load: {imm[11:0], rs1, funct3, rd, op}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
  - SB: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
  - Fields unused by a format are ignored.
- Legality checks:
  - I, load and S: imm_i must be in [-2048, 2047].
  - SB: imm_i must be in [-4096, 4094] and imm_i[0]=0.
  - R: imm_i ignored.
  - Any other opcode is illegal.
- Illegal request:
  - Still consumes the handshake (in_ready_o unaffected).
  - Produces no output word, does not change out_valid_o unless a simultaneous output transfer empties the register, and does not advance addr_o.
  - err_o pulses high for one cycle after the accept edge.
  - err_cnt_o increments and saturates at all-ones.
- in_valid_i=0: no state change except output transfer.
- Reset mid-operation: a pending word is lost and no transfer is reported.

Test Plan:
- Reset, then I request op=0010011 rd=1 rs1=0 funct3=0 imm=-1 with out_ready_i=1 -> next cycle instr_o=32'hFFF00093, addr_o=0, out_valid_o=1.
- Back-to-back S (op=0100011 f3=3 rs1=3 rs2=2 imm=8), then SB (op=1100011 f3=0 rs1=1 rs2=2 imm=-4) -> 32'h0021B423 @0, then 32'hFE208EE3 @4, no bubble.
- R (op=0110011 f7=0 rs2=2 rs1=1 f3=0 rd=3) with out_ready_i=0 for 3 cycles -> instr_o=32'h002081B3 held stable, in_ready_o=0. After release, load (op=0000011 f3=3 rd=5 rs1=6 imm=16) emits 32'h01033283 at addr+4.
- Illegal cases:
  - I with imm=2048 -> err_o pulse, err_cnt_o=1, no out_valid_o.
  - SB with imm=6 (legal, accepted as a control case), then SB with imm=5 -> err_cnt_o=2.
  - op=7'h7F -> err_cnt_o=3.
  - addr_o is unchanged across all rejected requests.
- 255+ illegal requests -> err_cnt_o saturates at 8'hFF.
- Assert rst_i while FULL with out_ready_i=0 -> out_valid_o drops immediately (asynchronously), addr_o=BASE_ADDR, err_cnt_o=0.
